// File: rtl/mul_issue_ctrl_pkg.sv
// Shared op encoding, FSM state encoding and op decode for the multiplier
// issue controller.
package mul_issue_ctrl_pkg;

   localparam int OP_W       = 3;
   localparam int OP_MUL_W   = 0;
   localparam int OP_MULH_W  = 1;
   localparam int OP_MULH_WU = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CALC  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef struct packed {
      logic hi;   // take upper result half
      logic sgn;  // signed multiply
   } op_dec_t;

   // mulh_w wins over mulh_wu, which wins over mul_w; all-zero behaves as mul_w.
   function automatic op_dec_t op_decode(input logic [OP_W-1:0] op);
      op_dec_t d;
      d = '0;
      if (op[OP_MULH_W]) begin
         d.hi  = 1'b1;
         d.sgn = 1'b1;
      end else if (op[OP_MULH_WU]) begin
         d.hi  = 1'b1;
      end else if (op[OP_MUL_W]) begin
         d = '0;
      end
      return d;
   endfunction

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// EXE/MEM handshakes and multiplier port bundle for mul_issue_ctrl.
interface mul_issue_ctrl_if #(
   parameter int XLEN   = 32,
   parameter int DEST_W = 5
);
   import mul_issue_ctrl_pkg::*;

   logic                in_valid;
   logic                in_ready;
   logic [OP_W-1:0]     in_op;
   logic [XLEN-1:0]     in_src1;
   logic [XLEN-1:0]     in_src2;
   logic [DEST_W-1:0]   in_dest;
   logic                flush;
   logic                mul_en;
   logic                mul_signed;
   logic [XLEN-1:0]     mul_x;
   logic [XLEN-1:0]     mul_y;
   logic [2*XLEN-1:0]   mul_result;
   logic                mul_complete;
   logic                out_valid;
   logic                out_ready;
   logic [XLEN-1:0]     out_result;
   logic [DEST_W-1:0]   out_dest;
   logic                busy;

   // Parent pipeline + multiplier side
   modport master (
      output in_valid, in_op, in_src1, in_src2, in_dest, flush,
             mul_result, mul_complete, out_ready,
      input  in_ready, mul_en, mul_signed, mul_x, mul_y,
             out_valid, out_result, out_dest, busy
   );

   // Controller side
   modport slave (
      input  in_valid, in_op, in_src1, in_src2, in_dest, flush,
             mul_result, mul_complete, out_ready,
      output in_ready, mul_en, mul_signed, mul_x, mul_y,
             out_valid, out_result, out_dest, busy
   );

endinterface

// File: rtl/mul_issue_ctrl.sv
// Sequencing front-end for the 2-cycle EXE multiplier: accepts an op, holds
// operands while the multiplier runs, and hands the selected half to MEM.
module mul_issue_ctrl
   import mul_issue_ctrl_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int DEST_W = 5
) (
   input  logic           clk,
   input  logic           resetn,
   mul_issue_ctrl_if.slave bus
);

   state_e              state_q;
   logic                mul_en_q;
   logic                sgn_q;
   logic                hi_q;
   logic [XLEN-1:0]     mul_x_q;
   logic [XLEN-1:0]     mul_y_q;
   logic [DEST_W-1:0]   dest_q;
   logic                out_valid_q;
   logic [XLEN-1:0]     out_result_q;
   logic [DEST_W-1:0]   out_dest_q;

   logic                in_ready_d;
   logic                accept_d;
   op_dec_t             dec_d;
   logic [XLEN-1:0]     result_d;

   // Flush always blocks a new op, even from a DONE slot that is draining.
   assign in_ready_d = !bus.flush &&
                       ((state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready));
   assign accept_d   = bus.in_valid && in_ready_d;
   assign dec_d      = op_decode(bus.in_op);
   assign result_d   = hi_q ? bus.mul_result[2*XLEN-1:XLEN] : bus.mul_result[XLEN-1:0];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         mul_en_q     <= 1'b0;
         sgn_q        <= 1'b0;
         hi_q         <= 1'b0;
         mul_x_q      <= '0;
         mul_y_q      <= '0;
         dest_q       <= '0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_dest_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_d) begin
                  state_q  <= ST_CALC;
                  mul_en_q <= 1'b1;
                  sgn_q    <= dec_d.sgn;
                  hi_q     <= dec_d.hi;
                  mul_x_q  <= bus.in_src1;
                  mul_y_q  <= bus.in_src2;
                  dest_q   <= bus.in_dest;
               end
            end
            ST_CALC: begin
               if (bus.flush) begin
                  // The multiplier's internal counter only clears on complete,
                  // so a flush before complete must keep mul_en high (DRAIN).
                  if (bus.mul_complete) begin
                     state_q  <= ST_IDLE;
                     mul_en_q <= 1'b0;
                  end else begin
                     state_q  <= ST_DRAIN;
                  end
               end else if (bus.mul_complete) begin
                  state_q      <= ST_DONE;
                  mul_en_q     <= 1'b0;
                  out_valid_q  <= 1'b1;
                  out_result_q <= result_d;
                  out_dest_q   <= dest_q;
               end
            end
            ST_DRAIN: begin
               if (bus.mul_complete) begin
                  state_q  <= ST_IDLE;
                  mul_en_q <= 1'b0;
               end
            end
            ST_DONE: begin
               if (bus.flush) begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b0;
               end else if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  if (accept_d) begin
                     state_q  <= ST_CALC;
                     mul_en_q <= 1'b1;
                     sgn_q    <= dec_d.sgn;
                     hi_q     <= dec_d.hi;
                     mul_x_q  <= bus.in_src1;
                     mul_y_q  <= bus.in_src2;
                     dest_q   <= bus.in_dest;
                  end else begin
                     state_q  <= ST_IDLE;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready   = in_ready_d;
   assign bus.mul_en     = mul_en_q;
   assign bus.mul_signed = sgn_q;
   assign bus.mul_x      = mul_x_q;
   assign bus.mul_y      = mul_y_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_result = out_result_q;
   assign bus.out_dest   = out_dest_q;
   assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: 2-cycle multiplier stand-in, transaction-age
// reference model checked every cycle, plus directed literal checks.
module tb_mul_issue_ctrl;
   import mul_issue_ctrl_pkg::*;

   localparam int XLEN   = 32;
   localparam int DEST_W = 5;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   mul_issue_ctrl_if #(.XLEN(XLEN), .DEST_W(DEST_W)) bus();

   mul_issue_ctrl #(.XLEN(XLEN), .DEST_W(DEST_W)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] p;
      p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      return p;
   endfunction

   function automatic logic [63:0] umul(input logic [31:0] a, input logic [31:0] b);
      return {32'd0, a} * {32'd0, b};
   endfunction

   function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] s, u;
      s = smul(a, b);
      u = umul(a, b);
      if (op[1])      return s[63:32];
      else if (op[2]) return u[63:32];
      else            return u[31:0];
   endfunction

   // Multiplier stand-in: complete in the 2nd enabled cycle, counter clears on complete
   logic mcnt_q;
   always @(posedge clk or negedge resetn) begin
      if (!resetn)         mcnt_q <= 1'b0;
      else if (bus.mul_en) mcnt_q <= ~mcnt_q;
   end
   assign bus.mul_complete = bus.mul_en & mcnt_q;
   assign bus.mul_result   = bus.mul_signed ? smul(bus.mul_x, bus.mul_y)
                                            : umul(bus.mul_x, bus.mul_y);

   // Reference model: one op tracked by age in cycles since its accept edge
   bit               m_have   = 0;
   bit               m_killed = 0;
   int               m_age    = 0;
   logic [31:0]      m_res, m_x, m_y;
   logic [DEST_W-1:0] m_dest;
   logic             m_sgn;

   initial forever begin
      bit ov, rdy, acc;
      @(posedge clk or negedge resetn);
      if (!resetn) begin
         m_have = 0;
      end else begin
         ov  = m_have && !m_killed && (m_age >= 3);
         rdy = !bus.flush && (!m_have || (ov && bus.out_ready));
         acc = bus.in_valid && rdy;
         if (m_have) begin
            if (m_age <= 2) begin
               if (bus.flush) m_killed = 1;
               m_age++;
               if (m_age == 3 && m_killed) m_have = 0;
            end else if (bus.flush || bus.out_ready) begin
               m_have = 0;
            end
         end
         if (acc) begin
            m_have   = 1;
            m_killed = 0;
            m_age    = 1;
            m_res    = ref_res(bus.in_op, bus.in_src1, bus.in_src2);
            m_x      = bus.in_src1;
            m_y      = bus.in_src2;
            m_dest   = bus.in_dest;
            m_sgn    = bus.in_op[1];
         end
      end
   end

   // Per-cycle compare against the model
   initial forever begin
      bit e_en, e_ov, e_rdy;
      @(negedge clk);
      if (resetn) begin
         e_en  = m_have && (m_age <= 2);
         e_ov  = m_have && !m_killed && (m_age >= 3);
         e_rdy = !bus.flush && (!m_have || (e_ov && bus.out_ready));
         chk("m_mul_en",    bus.mul_en,    e_en);
         chk("m_out_valid", bus.out_valid, e_ov);
         chk("m_busy",      bus.busy,      m_have);
         chk("m_in_ready",  bus.in_ready,  e_rdy);
         if (e_en) begin
            chk("m_mul_x",      bus.mul_x,      m_x);
            chk("m_mul_y",      bus.mul_y,      m_y);
            chk("m_mul_signed", bus.mul_signed, m_sgn);
         end
         if (e_ov) begin
            chk("m_out_result", bus.out_result, m_res);
            chk("m_out_dest",   bus.out_dest,   m_dest);
         end
      end
   end

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [DEST_W-1:0] d);
      int cnt;
      cnt = 0;
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_src1  = a;
      bus.in_src2  = b;
      bus.in_dest  = d;
      do begin
         @(negedge clk);
         cnt++;
      end while (!bus.in_ready && cnt < 30);
      if (!bus.in_ready) chk("issue_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(input string name, input logic [31:0] res,
                           input logic [DEST_W-1:0] d, input bit chk_rdy);
      int cnt;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!bus.out_valid && cnt < 30);
      chk({name, "_valid"}, bus.out_valid, 1'b1);
      chk({name, "_res"},   bus.out_result, res);
      chk({name, "_dest"},  bus.out_dest, d);
      if (chk_rdy) chk({name, "_in_ready"}, bus.in_ready, 1'b1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int en_cnt;
      bus.in_valid = 0; bus.in_op = '0; bus.in_src1 = '0; bus.in_src2 = '0;
      bus.in_dest = '0; bus.flush = 0; bus.out_ready = 1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mul_en",    bus.mul_en, 1'b0);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_busy",      bus.busy, 1'b0);
      chk("rst_mul_x",     bus.mul_x, 32'd0);
      chk("rst_out_res",   bus.out_result, 32'd0);
      resetn = 1'b1;
      @(posedge clk); #1;

      // Basic signed-high, latency and enable width
      issue(3'b010, 32'h8000_0000, 32'h8000_0000, 5'd5);
      en_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.mul_en) en_cnt++;
         if (i == 0) chk("t1_signed", bus.mul_signed, 1'b1);
      end
      chk("t1_valid_T3", bus.out_valid, 1'b1);
      chk("t1_res",      bus.out_result, 32'h4000_0000);
      chk("t1_en_cycles", en_cnt, 2);
      @(posedge clk); #1;

      // All ops on -1 * -1, plus decode priority and all-zero op
      issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
      wait_out("t2_mulw",   32'h0000_0001, 5'd1, 0);
      issue(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
      wait_out("t2_mulhwu", 32'hFFFF_FFFE, 5'd2, 0);
      issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
      wait_out("t2_mulhw",  32'h0000_0000, 5'd3, 0);
      issue(3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
      wait_out("t2_prio",   32'h0000_0000, 5'd4, 0);
      issue(3'b000, 32'd6, 32'd7, 5'd11);
      wait_out("t2_zero_op", 32'd42, 5'd11, 0);

      // Back-to-back with out_ready held
      fork
         begin
            issue(3'b001, 32'd7, 32'd6, 5'd1);
            issue(3'b001, 32'd7, 32'd6, 5'd2);
            issue(3'b001, 32'd7, 32'd6, 5'd3);
         end
         begin
            wait_out("t3_b2b0", 32'd42, 5'd1, 1);
            wait_out("t3_b2b1", 32'd42, 5'd2, 1);
            wait_out("t3_b2b2", 32'd42, 5'd3, 1);
         end
      join
      repeat (2) @(posedge clk); #1;

      // Backpressure in DONE with a waiting op
      bus.out_ready = 0;
      issue(3'b001, 32'd9, 32'd9, 5'd4);
      bus.in_valid = 1; bus.in_op = 3'b001; bus.in_src1 = 32'd2; bus.in_src2 = 32'd3;
      bus.in_dest = 5'd6;
      repeat (2) @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_hold_valid", bus.out_valid, 1'b1);
         chk("t4_hold_res",   bus.out_result, 32'd81);
         chk("t4_hold_dest",  bus.out_dest, 5'd4);
         chk("t4_hold_rdy",   bus.in_ready, 1'b0);
      end
      @(posedge clk); #1;
      bus.out_ready = 1;
      @(posedge clk); #1;
      bus.in_valid = 0;
      @(negedge clk);
      chk("t4_one_xfer", bus.out_valid, 1'b0);
      @(posedge clk); #1;
      wait_out("t4_next", 32'd6, 5'd6, 0);

      // Flush in first CALC cycle, held into DRAIN
      issue(3'b001, 32'd11, 32'd13, 5'd7);
      bus.flush = 1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("t5_drain_en",    bus.mul_en, 1'b1);
      chk("t5_drain_valid", bus.out_valid, 1'b0);
      chk("t5_drain_busy",  bus.busy, 1'b1);
      @(posedge clk); #1;
      bus.flush = 0;
      @(negedge clk);
      chk("t5_idle_en",    bus.mul_en, 1'b0);
      chk("t5_idle_busy",  bus.busy, 1'b0);
      repeat (3) @(posedge clk); #1;
      issue(3'b001, 32'd3, 32'd5, 5'd8);
      wait_out("t5_after", 32'd15, 5'd8, 0);

      // Flush on the completing CALC cycle
      issue(3'b100, 32'd100, 32'd100, 5'd12);
      @(posedge clk); #1;
      bus.flush = 1;
      @(posedge clk); #1;
      bus.flush = 0;
      @(negedge clk);
      chk("t6_cflush_busy",  bus.busy, 1'b0);
      chk("t6_cflush_valid", bus.out_valid, 1'b0);

      // Flush in DONE beats a same-cycle in_valid
      bus.out_ready = 0;
      @(posedge clk); #1;
      issue(3'b001, 32'd2, 32'd2, 5'd10);
      repeat (3) @(posedge clk); #1;
      bus.flush = 1; bus.in_valid = 1; bus.in_op = 3'b001;
      bus.in_src1 = 32'd5; bus.in_src2 = 32'd5; bus.in_dest = 5'd13;
      @(posedge clk); #1;
      bus.flush = 0; bus.in_valid = 0;
      @(negedge clk);
      chk("t7_dflush_valid", bus.out_valid, 1'b0);
      chk("t7_dflush_busy",  bus.busy, 1'b0);
      @(posedge clk); #1;
      bus.out_ready = 1;

      // Async reset during CALC
      issue(3'b100, 32'hFFFF_FFFF, 32'd2, 5'd9);
      @(negedge clk);
      #3 resetn = 0;
      #1;
      chk("t8_rst_en",    bus.mul_en, 1'b0);
      chk("t8_rst_valid", bus.out_valid, 1'b0);
      chk("t8_rst_busy",  bus.busy, 1'b0);
      chk("t8_rst_x",     bus.mul_x, 32'd0);
      chk("t8_rst_y",     bus.mul_y, 32'd0);
      chk("t8_rst_sgn",   bus.mul_signed, 1'b0);
      chk("t8_rst_res",   bus.out_result, 32'd0);
      chk("t8_rst_dest",  bus.out_dest, 5'd0);
      @(posedge clk); #1;
      resetn = 1;
      @(posedge clk); #1;
      issue(3'b001, 32'd4, 32'd5, 5'd9);
      wait_out("t8_after", 32'd20, 5'd9, 0);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
